rv64g_l2_array_ctrl: RTL and testbench

RV64G_L2_ARRAY_CTRL -- requirements
Module: rv64g_l2_array_ctrl

---
 rtl/rv64g_l2_array_ctrl.sv | 126 ++++++++++++
 tb/tb_rv64g_l2_array_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64g_l2_array_ctrl.sv
// rtl/rv64g_l2_array_ctrl.sv - L2 data/tag array sequencer: 8-beat line refill plus single-word core access.
module rv64g_l2_array_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fill_req_valid_i,
  output logic        fill_req_ready_o,
  input  logic [7:0]  fill_index_i,
  input  logic [3:0]  fill_way_i,
  input  logic [49:0] fill_tag_i,
  input  logic        fill_data_valid_i,
  output logic        fill_data_ready_o,
  input  logic [63:0] fill_data_i,
  input  logic        core_req_valid_i,
  output logic        core_req_ready_o,
  input  logic        core_we_i,
  input  logic [7:0]  core_index_i,
  input  logic [2:0]  core_word_i,
  input  logic [3:0]  core_way_i,
  input  logic [7:0]  core_be_i,
  input  logic [49:0] core_tag_i,
  input  logic [63:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [63:0] core_rdata_o,
  output logic [7:0]  arr_index_o,
  output logic [2:0]  arr_word_sel_o,
  output logic [3:0]  arr_way_sel_o,
  output logic        arr_write_en_o,
  output logic [7:0]  arr_be_o,
  output logic [49:0] arr_tag_o,
  output logic [63:0] arr_wdata_o,
  input  logic [63:0] arr_rdata_i,
  output logic        busy_o,
  output logic        fill_done_o
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state;
  logic [2:0]  beat;
  logic [7:0]  line_index;
  logic [3:0]  line_way;
  logic [49:0] line_tag;
  logic        core_prio;

  logic fill_req_fire;
  logic core_fire;
  logic beat_fire;

  // core_prio lets one core access slip in after a fill even when fill requests keep coming
  assign fill_req_ready_o  = (state == IDLE) && !(core_prio && core_req_valid_i);
  assign core_req_ready_o  = (state == IDLE) && (!fill_req_valid_i || core_prio);
  assign fill_data_ready_o = (state == FILL);
  assign busy_o            = (state != IDLE);
  assign fill_done_o       = (state == DONE);

  assign fill_req_fire = fill_req_valid_i && fill_req_ready_o;
  assign core_fire     = core_req_valid_i && core_req_ready_o;
  assign beat_fire     = fill_data_valid_i && fill_data_ready_o;

  always_comb begin
    arr_index_o    = 8'd0;
    arr_word_sel_o = 3'd0;
    arr_way_sel_o  = 4'd0;
    arr_write_en_o = 1'b0;
    arr_be_o       = 8'd0;
    arr_tag_o      = 50'd0;
    arr_wdata_o    = 64'd0;
    if (beat_fire) begin
      arr_index_o    = line_index;
      arr_word_sel_o = beat;
      arr_way_sel_o  = line_way;
      arr_write_en_o = 1'b1;
      arr_be_o       = 8'hFF;
      arr_tag_o      = line_tag;
      arr_wdata_o    = fill_data_i;
    end else if (core_fire) begin
      arr_index_o    = core_index_i;
      arr_word_sel_o = core_word_i;
      arr_way_sel_o  = core_way_i;
      arr_write_en_o = core_we_i;
      arr_be_o       = core_we_i ? core_be_i : 8'd0;
      arr_tag_o      = core_tag_i;
      arr_wdata_o    = core_we_i ? core_wdata_i : 64'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      beat          <= 3'd0;
      line_index    <= 8'd0;
      line_way      <= 4'd0;
      line_tag      <= 50'd0;
      core_prio     <= 1'b0;
      core_rvalid_o <= 1'b0;
      core_rdata_o  <= 64'd0;
    end else begin
      core_rvalid_o <= core_fire && !core_we_i;
      if (core_fire && !core_we_i) core_rdata_o <= arr_rdata_i;
      case (state)
        IDLE: begin
          if (core_fire) core_prio <= 1'b0;
          if (fill_req_fire) begin
            line_index <= fill_index_i;
            line_way   <= fill_way_i;
            line_tag   <= fill_tag_i;
            beat       <= 3'd0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (beat_fire) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) state <= DONE;
          end
        end
        DONE: begin
          if (core_req_valid_i) core_prio <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64g_l2_array_ctrl.sv
// tb/tb_rv64g_l2_array_ctrl.sv - scoreboard bench for rv64g_l2_array_ctrl with a behavioural array model.
module tb_rv64g_l2_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fill_req_valid_i, fill_req_ready_o;
  logic [7:0]  fill_index_i;
  logic [3:0]  fill_way_i;
  logic [49:0] fill_tag_i;
  logic        fill_data_valid_i, fill_data_ready_o;
  logic [63:0] fill_data_i;
  logic        core_req_valid_i, core_req_ready_o, core_we_i;
  logic [7:0]  core_index_i;
  logic [2:0]  core_word_i;
  logic [3:0]  core_way_i;
  logic [7:0]  core_be_i;
  logic [49:0] core_tag_i;
  logic [63:0] core_wdata_i;
  logic        core_rvalid_o;
  logic [63:0] core_rdata_o;
  logic [7:0]  arr_index_o;
  logic [2:0]  arr_word_sel_o;
  logic [3:0]  arr_way_sel_o;
  logic        arr_write_en_o;
  logic [7:0]  arr_be_o;
  logic [49:0] arr_tag_o;
  logic [63:0] arr_wdata_o;
  logic [63:0] arr_rdata_i;
  logic        busy_o, fill_done_o;

  int tests_run = 0;
  int fails = 0;
  logic [136:0] exp_wr[$];
  logic [63:0]  exp_rd[$];
  logic [136:0] act_w, exp_w;
  logic [63:0]  exp_r;
  logic [63:0]  mem [0:32767];
  logic         core_rdy_seen;

  localparam logic [63:0] BASE_A = 64'hD0D1D2D3_00000000;
  localparam logic [63:0] RD_A   = 64'hD0D1D2D3_11111111;

  always #5 clk = ~clk;

  rv64g_l2_array_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .fill_req_valid_i(fill_req_valid_i), .fill_req_ready_o(fill_req_ready_o),
    .fill_index_i(fill_index_i), .fill_way_i(fill_way_i), .fill_tag_i(fill_tag_i),
    .fill_data_valid_i(fill_data_valid_i), .fill_data_ready_o(fill_data_ready_o), .fill_data_i(fill_data_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o), .core_we_i(core_we_i),
    .core_index_i(core_index_i), .core_word_i(core_word_i), .core_way_i(core_way_i),
    .core_be_i(core_be_i), .core_tag_i(core_tag_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o), .arr_way_sel_o(arr_way_sel_o),
    .arr_write_en_o(arr_write_en_o), .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o),
    .arr_wdata_o(arr_wdata_o), .arr_rdata_i(arr_rdata_i),
    .busy_o(busy_o), .fill_done_o(fill_done_o)
  );

  // Array model: byte-masked writes on the clock, combinational read
  assign arr_rdata_i = mem[{arr_way_sel_o, arr_index_o, arr_word_sel_o}];
  always @(posedge clk) begin
    if (arr_write_en_o === 1'b1)
      for (int i = 0; i < 8; i++)
        if (arr_be_o[i]) mem[{arr_way_sel_o, arr_index_o, arr_word_sel_o}][8*i +: 8] <= arr_wdata_o[8*i +: 8];
  end

  always @(negedge clk) begin
    act_w = {arr_index_o, arr_word_sel_o, arr_way_sel_o, arr_be_o, arr_tag_o, arr_wdata_o};
    if (arr_write_en_o === 1'b1) begin
      tests_run++;
      if (exp_wr.size() == 0) begin
        fails++; $display("FAIL unexpected_write got %h required none", act_w);
      end else begin
        exp_w = exp_wr.pop_front();
        if (act_w !== exp_w) begin fails++; $display("FAIL array_write got %h required %h", act_w, exp_w); end
      end
    end else if (arr_be_o !== 8'd0) begin
      tests_run++; fails++; $display("FAIL be_without_write got %h required 00", arr_be_o);
    end
    if (core_rvalid_o === 1'b1) begin
      tests_run++;
      if (exp_rd.size() == 0) begin
        fails++; $display("FAIL unexpected_rvalid rdata %h required no rvalid", core_rdata_o);
      end else begin
        exp_r = exp_rd.pop_front();
        if (core_rdata_o !== exp_r) begin fails++; $display("FAIL read_data got %h required %h", core_rdata_o, exp_r); end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic fill_req(input logic [7:0] idx, input logic [3:0] way, input logic [49:0] tag, input bit hold);
    int n;
    n = 0;
    fill_index_i = idx; fill_way_i = way; fill_tag_i = tag; fill_req_valid_i = 1'b1;
    @(negedge clk);
    while (fill_req_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    core_rdy_seen = core_req_ready_o;
    tests_run++;
    if (fill_req_ready_o !== 1'b1) begin fails++; $display("FAIL fill_req_accept ready=%b required 1", fill_req_ready_o); end
    if (arr_write_en_o !== 1'b0) begin fails++; $display("FAIL write_on_fill_req we=%b required 0", arr_write_en_o); end
    tick;
    if (!hold) fill_req_valid_i = 1'b0;
  endtask

  task automatic run_beats(input logic [7:0] idx, input logic [3:0] way, input logic [49:0] tag,
                           input int first, input int last, input int gap_after, input int gap_len,
                           input logic [63:0] base);
    logic [63:0] d;
    for (int b = first; b <= last; b++) begin
      d = base + 64'(b);
      fill_data_valid_i = 1'b1; fill_data_i = d;
      exp_wr.push_back({idx, 3'(b), way, 8'hFF, tag, d});
      @(negedge clk);
      tests_run++;
      if (fill_data_ready_o !== 1'b1 || busy_o !== 1'b1 || core_req_ready_o !== 1'b0 || fill_req_ready_o !== 1'b0) begin
        fails++; $display("FAIL fill_state beat %0d data_rdy=%b busy=%b core_rdy=%b fill_rdy=%b required 1 1 0 0",
                          b, fill_data_ready_o, busy_o, core_req_ready_o, fill_req_ready_o);
      end
      tick;
      if (b == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          fill_data_valid_i = 1'b0; fill_data_i = 64'hBAD0BAD0BAD0BAD0;
          @(negedge clk);
          tests_run++;
          if (arr_write_en_o !== 1'b0 || fill_data_ready_o !== 1'b1) begin
            fails++; $display("FAIL stall_gap we=%b data_rdy=%b required 0 1", arr_write_en_o, fill_data_ready_o);
          end
          tick;
        end
      end
    end
    fill_data_valid_i = 1'b0;
  endtask

  task automatic check_done;
    fill_data_valid_i = 1'b1; fill_data_i = 64'hDEADDEADDEADDEAD;
    @(negedge clk);
    tests_run++;
    if (fill_done_o !== 1'b1 || busy_o !== 1'b1 || fill_req_ready_o !== 1'b0 || core_req_ready_o !== 1'b0 || fill_data_ready_o !== 1'b0) begin
      fails++; $display("FAIL done_state done=%b busy=%b fill_rdy=%b core_rdy=%b data_rdy=%b required 1 1 0 0 0",
                        fill_done_o, busy_o, fill_req_ready_o, core_req_ready_o, fill_data_ready_o);
    end
    tick;
    fill_data_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    fill_req_valid_i = 0; fill_index_i = 0; fill_way_i = 0; fill_tag_i = 0;
    fill_data_valid_i = 0; fill_data_i = 0;
    core_req_valid_i = 0; core_we_i = 0; core_index_i = 0; core_word_i = 0; core_way_i = 0;
    core_be_i = 0; core_tag_i = 0; core_wdata_i = 0;
    repeat (3) tick;
    rst_i = 1'b0;
    fill_data_valid_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy_o !== 0 || fill_done_o !== 0 || arr_write_en_o !== 0 || core_rvalid_o !== 0 || core_rdata_o !== 64'd0) begin
      fails++; $display("FAIL reset_outputs busy=%b done=%b we=%b rvalid=%b rdata=%h required all 0",
                        busy_o, fill_done_o, arr_write_en_o, core_rvalid_o, core_rdata_o);
    end
    tests_run++;
    if ({arr_index_o, arr_word_sel_o, arr_way_sel_o, arr_tag_o, arr_wdata_o} !== 127'd0) begin
      fails++; $display("FAIL reset_arr idx=%h word=%h way=%h tag=%h wdata=%h required 0",
                        arr_index_o, arr_word_sel_o, arr_way_sel_o, arr_tag_o, arr_wdata_o);
    end
    tests_run++;
    if (fill_req_ready_o !== 1 || core_req_ready_o !== 1 || fill_data_ready_o !== 0) begin
      fails++; $display("FAIL reset_ready fill_rdy=%b core_rdy=%b data_rdy=%b required 1 1 0",
                        fill_req_ready_o, core_req_ready_o, fill_data_ready_o);
    end
    tick;
    fill_data_valid_i = 1'b0;
  endtask

  task automatic test_fill;
    fill_req(8'd10, 4'd5, 50'h123456789ABC, 1'b0);
    run_beats(8'd10, 4'd5, 50'h123456789ABC, 0, 7, -1, 0, BASE_A);
    check_done;
    @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0 || fill_done_o !== 1'b0) begin
      fails++; $display("FAIL after_done busy=%b done=%b required 0 0", busy_o, fill_done_o);
    end
    tick;
  endtask

  task automatic test_core_write_read;
    core_req_valid_i = 1; core_we_i = 1; core_index_i = 8'd10; core_word_i = 3'd2; core_way_i = 4'd5;
    core_be_i = 8'h0F; core_tag_i = 50'h1; core_wdata_i = 64'h11111111;
    exp_wr.push_back({8'd10, 3'd2, 4'd5, 8'h0F, 50'h1, 64'h11111111});
    @(negedge clk);
    tests_run++;
    if (core_req_ready_o !== 1'b1 || core_rvalid_o !== 1'b0) begin
      fails++; $display("FAIL core_write_accept rdy=%b rvalid=%b required 1 0", core_req_ready_o, core_rvalid_o);
    end
    tick;
    core_we_i = 0; core_be_i = 8'h00;
    exp_rd.push_back(RD_A);
    @(negedge clk);
    tests_run++;
    if (core_req_ready_o !== 1'b1 || arr_write_en_o !== 1'b0 || {arr_index_o, arr_word_sel_o, arr_way_sel_o} !== {8'd10, 3'd2, 4'd5}) begin
      fails++; $display("FAIL core_read_addr rdy=%b we=%b addr=%h/%h/%h required 1 0 0a/2/5",
                        core_req_ready_o, arr_write_en_o, arr_index_o, arr_word_sel_o, arr_way_sel_o);
    end
    tests_run++;
    if (core_rvalid_o !== 1'b0) begin fails++; $display("FAIL read_latency_early rvalid=%b required 0", core_rvalid_o); end
    tick;
    core_req_valid_i = 0;
    @(negedge clk);
    tests_run++;
    if (core_rvalid_o !== 1'b1) begin fails++; $display("FAIL read_latency rvalid=%b required 1", core_rvalid_o); end
    tick;
    @(negedge clk);
    tests_run++;
    if (core_rvalid_o !== 1'b0 || core_rdata_o !== RD_A) begin
      fails++; $display("FAIL rdata_hold rvalid=%b rdata=%h required 0 %h", core_rvalid_o, core_rdata_o, RD_A);
    end
    tick;
  endtask

  task automatic test_stall;
    fill_req(8'd20, 4'd2, 50'h2222, 1'b0);
    run_beats(8'd20, 4'd2, 50'h2222, 0, 7, 3, 3, 64'h5500000000000000);
    check_done;
  endtask

  task automatic test_back_to_back;
    core_req_valid_i = 1; core_we_i = 0; core_index_i = 8'd10; core_word_i = 3'd2; core_way_i = 4'd5;
    core_be_i = 8'h00; core_tag_i = 50'h3;
    exp_rd.push_back(RD_A);
    fill_req(8'd30, 4'd1, 50'h3030, 1'b1);
    tests_run++;
    if (core_rdy_seen !== 1'b0) begin fails++; $display("FAIL fill_wins_tie core_rdy=%b required 0", core_rdy_seen); end
    run_beats(8'd30, 4'd1, 50'h3030, 0, 7, -1, 0, 64'h3000000000000000);
    check_done;
    @(negedge clk);
    tests_run++;
    if (core_req_ready_o !== 1'b1 || fill_req_ready_o !== 1'b0) begin
      fails++; $display("FAIL core_prio core_rdy=%b fill_rdy=%b required 1 0", core_req_ready_o, fill_req_ready_o);
    end
    tick;
    fill_req(8'd31, 4'd1, 50'h3131, 1'b1);
    tests_run++;
    if (core_rdy_seen !== 1'b0) begin fails++; $display("FAIL prio_cleared core_rdy=%b required 0", core_rdy_seen); end
    run_beats(8'd31, 4'd1, 50'h3131, 0, 7, -1, 0, 64'h3100000000000000);
    check_done;
    exp_rd.push_back(RD_A);
    @(negedge clk);
    tests_run++;
    if (core_req_ready_o !== 1'b1 || fill_req_ready_o !== 1'b0) begin
      fails++; $display("FAIL core_prio_2 core_rdy=%b fill_rdy=%b required 1 0", core_req_ready_o, fill_req_ready_o);
    end
    tick;
    fill_req_valid_i = 0; core_req_valid_i = 0;
    repeat (2) tick;
  endtask

  task automatic test_reset_mid_fill;
    fill_req(8'd40, 4'd3, 50'h4040, 1'b0);
    run_beats(8'd40, 4'd3, 50'h4040, 0, 4, -1, 0, 64'h4000000000000000);
    fill_data_valid_i = 1'b1; fill_data_i = 64'h4000000000000005;
    rst_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (arr_write_en_o !== 0 || busy_o !== 0 || fill_done_o !== 0 || fill_data_ready_o !== 0) begin
      fails++; $display("FAIL reset_abort we=%b busy=%b done=%b data_rdy=%b required 0 0 0 0",
                        arr_write_en_o, busy_o, fill_done_o, fill_data_ready_o);
    end
    tick;
    @(negedge clk);
    tests_run++;
    if (fill_done_o !== 0 || core_rdata_o !== 64'd0) begin
      fails++; $display("FAIL reset_hold done=%b rdata=%h required 0 0", fill_done_o, core_rdata_o);
    end
    tick;
    rst_i = 1'b0; fill_data_valid_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (fill_done_o !== 0 || busy_o !== 0) begin
      fails++; $display("FAIL after_abort done=%b busy=%b required 0 0", fill_done_o, busy_o);
    end
    tick;
    fill_req(8'd41, 4'd3, 50'h4141, 1'b0);
    run_beats(8'd41, 4'd3, 50'h4141, 0, 7, -1, 0, 64'h4100000000000000);
    check_done;
    repeat (2) tick;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_core_write_read;
    test_stall;
    test_back_to_back;
    test_reset_mid_fill;
    tests_run++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain writes_left=%0d reads_left=%0d required 0 0", exp_wr.size(), exp_rd.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
